// File: rtl/vga_pixel_fetch.sv
`default_nettype none
// ============================================================================
// Module   : vga_pixel_fetch
// Purpose  : Pixel source for the VGA controller. Walks the full frame
//            (blanking included), fetches packed 3-bit RGB pixels from a
//            video RAM one word at a time, and serialises them onto oPixel
//            with the matching display position.
//            The RAM answers every read exactly one cycle later. A two-stage
//            fetch-ahead pipeline absorbs that latency, so the display
//            position is the fetch position delayed by two enabled cycles.
// Ports    : Clock        pixel clock, all logic on posedge
//            Reset        asynchronous, active-high
//            Enable       advance one pixel per cycle; hold everything when 0
//            oRamRead     read strobe, one cycle per word
//            oRamAddress  word address, valid while oRamRead=1
//            iRamData     read data, valid one cycle after oRamRead
//            oPixel       {R,G,B} for the position on oColumn/oRow
//            oColumn      display column 0..H_TOTAL-1
//            oRow         display row 0..V_TOTAL-1
//            oFrameStart  one-cycle pulse at display position (0,0)
// Options  : VGA_FETCH_BORDER_EN  when defined, forces a white (3'b111)
//            one-pixel border around the active area. RAM traffic does not
//            change.
// Revision : 1.0  initial release
// ============================================================================
module vga_pixel_fetch #(
    parameter int H_TOTAL      = 800,
    parameter int V_TOTAL      = 521,
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int PIX_PER_WORD = 8,
    parameter int ADDR_WIDTH   = 16
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      Enable,
    output logic                      oRamRead,
    output logic [ADDR_WIDTH-1:0]     oRamAddress,
    input  logic [3*PIX_PER_WORD-1:0] iRamData,
    output logic [2:0]                oPixel,
    output logic [9:0]                oColumn,
    output logic [9:0]                oRow,
    output logic                      oFrameStart
);

    localparam int         c_WORD_W    = 3 * PIX_PER_WORD;
    localparam logic [9:0] c_H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] c_H_PRELAST = 10'(H_TOTAL - 2);
    localparam logic [9:0] c_V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] c_H_ACT     = 10'(H_ACTIVE);
    localparam logic [9:0] c_V_ACT     = 10'(V_ACTIVE);
    localparam logic [9:0] c_WORD_MASK = 10'(PIX_PER_WORD - 1);

    // Fetch position, one-stage-delayed position and display position.
    logic [9:0]            r_fetchCol;
    logic [9:0]            r_fetchRow;
    logic [9:0]            r_stageCol;
    logic [9:0]            r_stageRow;
    logic [9:0]            r_column;
    logic [9:0]            r_row;
    logic [ADDR_WIDTH-1:0] r_wordCount;
    logic [c_WORD_W-1:0]   r_shift;
    logic                  r_loadPending;
    logic                  r_frameStart;

    logic                  w_fetchSlot;
    logic                  w_read;
    logic                  w_lineEnd;
    logic                  w_frameEnd;
    logic                  w_active;

    // A word is fetched on the first column of every word-aligned group
    // inside the active area.
    assign w_fetchSlot = (r_fetchCol < c_H_ACT) && (r_fetchRow < c_V_ACT) &&
                         ((r_fetchCol & c_WORD_MASK) == 10'd0);
    assign w_read      = Enable && w_fetchSlot;
    assign w_lineEnd   = (r_fetchCol == c_H_LAST);
    assign w_frameEnd  = w_lineEnd && (r_fetchRow == c_V_LAST);

    assign oRamRead    = w_read;
    assign oRamAddress = r_wordCount;
    assign oColumn     = r_column;
    assign oRow        = r_row;
    assign oFrameStart = r_frameStart;

    // Fetch counters and the word address counter.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_fetchCol  <= 10'd0;
            r_fetchRow  <= 10'd0;
            r_wordCount <= '0;
        end else if (Enable) begin
            if (w_lineEnd) begin
                r_fetchCol <= 10'd0;
                r_fetchRow <= (r_fetchRow == c_V_LAST) ? 10'd0 : r_fetchRow + 10'd1;
            end else begin
                r_fetchCol <= r_fetchCol + 10'd1;
            end
            // The last read of a frame leaves the counter one past the end;
            // rewind it before fetch position (0,0) comes round again.
            if (w_frameEnd) begin
                r_wordCount <= '0;
            end else if (w_read) begin
                r_wordCount <= r_wordCount + 1'b1;
            end
        end
    end

    // Position pipeline: stage-1 is one enabled cycle behind fetch, the
    // display position one further. Reset values are the fetch reset
    // position wound back by one and two cycles respectively.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_stageCol   <= c_H_LAST;
            r_stageRow   <= c_V_LAST;
            r_column     <= c_H_PRELAST;
            r_row        <= c_V_LAST;
            r_frameStart <= 1'b0;
        end else if (Enable) begin
            r_stageCol   <= r_fetchCol;
            r_stageRow   <= r_fetchRow;
            r_column     <= r_stageCol;
            r_row        <= r_stageRow;
            r_frameStart <= (r_stageCol == 10'd0) && (r_stageRow == 10'd0);
        end
    end

    // Pixel shift register. The word requested in cycle t arrives in cycle
    // t+1 and is captured at the end of it; every other enabled cycle moves
    // the next pixel down into bits [2:0].
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_loadPending <= 1'b0;
            r_shift       <= '0;
        end else if (Enable) begin
            r_loadPending <= w_read;
            if (r_loadPending) begin
                r_shift <= iRamData;
            end else begin
                r_shift <= {3'b000, r_shift[c_WORD_W-1:3]};
            end
        end
    end

    assign w_active = (r_column < c_H_ACT) && (r_row < c_V_ACT);

    always_comb begin
        oPixel = 3'b000;
        if (w_active) begin
            oPixel = r_shift[2:0];
`ifdef VGA_FETCH_BORDER_EN
            if ((r_column == 10'd0) || (r_column == c_H_ACT - 10'd1) ||
                (r_row == 10'd0) || (r_row == c_V_ACT - 10'd1)) begin
                oPixel = 3'b111;
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_pixel_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_pixel_fetch
// Purpose  : Directed self-checking bench for vga_pixel_fetch. A full-size
//            instance covers reset, fetch timing, blanking, pause and
//            asynchronous reset; a reduced-geometry instance (20x10 frame,
//            16x6 active) covers frame wrap within a short run.
// Revision : 1.0  initial release
// ============================================================================
module tb_vga_pixel_fetch;

    localparam int FRAME  = 800 * 521;
    localparam int FRAME2 = 20 * 10;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Enable = 1'b0;
    logic        oRamRead,  oRamRead2;
    logic [15:0] oRamAddress, oRamAddress2;
    logic [23:0] iRamData = '0;
    logic [23:0] iRamData2 = '0;
    logic [2:0]  oPixel, oPixel2;
    logic [9:0]  oColumn, oRow, oColumn2, oRow2;
    logic        oFrameStart, oFrameStart2;

    int checks = 0;
    int errors = 0;
    int n = 0;  // enabled clock edges since reset was released

    always #5 Clock = ~Clock;

    vga_pixel_fetch dut (
        .Clock(Clock), .Reset(Reset), .Enable(Enable),
        .oRamRead(oRamRead), .oRamAddress(oRamAddress), .iRamData(iRamData),
        .oPixel(oPixel), .oColumn(oColumn), .oRow(oRow), .oFrameStart(oFrameStart)
    );

    vga_pixel_fetch #(
        .H_TOTAL(20), .V_TOTAL(10), .H_ACTIVE(16), .V_ACTIVE(6),
        .PIX_PER_WORD(8), .ADDR_WIDTH(16)
    ) dut2 (
        .Clock(Clock), .Reset(Reset), .Enable(Enable),
        .oRamRead(oRamRead2), .oRamAddress(oRamAddress2), .iRamData(iRamData2),
        .oPixel(oPixel2), .oColumn(oColumn2), .oRow(oRow2), .oFrameStart(oFrameStart2)
    );

    // Pixel k of word a holds (a + k + 1) mod 8, so every pixel slot of
    // every word is distinguishable from its neighbours.
    function automatic logic [23:0] pattern(input logic [15:0] a);
        logic [23:0] d;
        d = '0;
        for (int k = 0; k < 8; k++) d[3*k +: 3] = a[2:0] + 3'(k + 1);
        return d;
    endfunction

    // One-cycle-latency RAM models.
    always @(posedge Clock) begin
        if (oRamRead)  iRamData  <= pattern(oRamAddress);
        if (oRamRead2) iRamData2 <= pattern(oRamAddress2);
    end

    function automatic logic [2:0] expPix(input int col, input int row);
        int word;
        if (col >= 640 || row >= 480) return 3'b000;
`ifdef VGA_FETCH_BORDER_EN
        if (col == 0 || col == 639 || row == 0 || row == 479) return 3'b111;
`endif
        word = row * 80 + col / 8;
        return 3'((word + col % 8 + 1) % 8);
    endfunction

    function automatic int dispPos(input int cnt, input int total);
        return (cnt + total - 2) % total;
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
        if (Enable) n++;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge Clock);
        #1;
        checks++; if (oColumn !== 10'd798) begin errors++; $display("FAIL reset_col got %0d want 798", oColumn); end
        checks++; if (oRow !== 10'd520) begin errors++; $display("FAIL reset_row got %0d want 520", oRow); end
        checks++; if (oPixel !== 3'd0) begin errors++; $display("FAIL reset_pix got %0d want 0", oPixel); end
        checks++; if (oRamRead !== 1'b0) begin errors++; $display("FAIL reset_read got %0b want 0", oRamRead); end
        checks++; if (oRamAddress !== 16'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", oRamAddress); end
        checks++; if (oFrameStart !== 1'b0) begin errors++; $display("FAIL reset_fs got %0b want 0", oFrameStart); end
        checks++; if (oColumn2 !== 10'd18 || oRow2 !== 10'd9) begin errors++; $display("FAIL reset_small_pos got %0d,%0d want 18,9", oColumn2, oRow2); end
        Reset = 1'b0;
        n = 0;
    endtask

    task automatic test_first_word();
        Enable = 1'b1;
        #1;
        checks++; if (oRamRead !== 1'b1) begin errors++; $display("FAIL first_read got %0b want 1", oRamRead); end
        checks++; if (oRamAddress !== 16'd0) begin errors++; $display("FAIL first_addr got %0d want 0", oRamAddress); end
        tick();
        tick();
        checks++; if (oColumn !== 10'd0 || oRow !== 10'd0) begin errors++; $display("FAIL first_pos got %0d,%0d want 0,0", oColumn, oRow); end
        checks++; if (oFrameStart !== 1'b1) begin errors++; $display("FAIL first_fs got %0b want 1", oFrameStart); end
        checks++; if (oPixel !== expPix(0, 0)) begin errors++; $display("FAIL first_pix got %0d want %0d", oPixel, expPix(0, 0)); end
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++; if (oColumn !== 10'(k)) begin errors++; $display("FAIL word_col got %0d want %0d", oColumn, k); end
            checks++; if (oPixel !== expPix(k, 0)) begin errors++; $display("FAIL word_pix col %0d got %0d want %0d", k, oPixel, expPix(k, 0)); end
            checks++; if (oFrameStart !== 1'b0) begin errors++; $display("FAIL word_fs col %0d got 1 want 0", k); end
        end
    endtask

    // Runs through the rest of line 0 into line 1, checking reads, addresses
    // and displayed pixels every cycle.
    task automatic test_hblank();
        int f, fh, fv, d, dc, dr;
        logic expRead;
        while (n < 820) begin
            f = n % FRAME; fh = f % 800; fv = f / 800;
            expRead = (fh < 640) && (fv < 480) && (fh % 8 == 0);
            d = dispPos(n, FRAME); dc = d % 800; dr = d / 800;
            checks++; if (oRamRead !== expRead) begin errors++; $display("FAIL hb_read fh %0d got %0b want %0b", fh, oRamRead, expRead); end
            if (expRead) begin
                checks++; if (oRamAddress !== 16'(fv * 80 + fh / 8)) begin errors++; $display("FAIL hb_addr fh %0d fv %0d got %0d want %0d", fh, fv, oRamAddress, fv * 80 + fh / 8); end
            end
            if (fh == 0 && fv == 1) begin
                checks++; if (oRamAddress !== 16'd80) begin errors++; $display("FAIL row1_addr got %0d want 80", oRamAddress); end
            end
            checks++; if (oColumn !== 10'(dc) || oRow !== 10'(dr)) begin errors++; $display("FAIL hb_pos got %0d,%0d want %0d,%0d", oColumn, oRow, dc, dr); end
            checks++; if (oPixel !== expPix(dc, dr)) begin errors++; $display("FAIL hb_pix col %0d row %0d got %0d want %0d", dc, dr, oPixel, expPix(dc, dr)); end
            tick();
        end
    endtask

    // Reduced-geometry instance: 12 words per frame, last address 11.
    task automatic test_frame_wrap();
        int f, fh, fv, stop, pulses, lastAddr;
        logic expRead, expFs;
        stop = n + 400;
        pulses = 0;
        lastAddr = -1;
        while (n < stop) begin
            f = n % FRAME2; fh = f % 20; fv = f / 20;
            expRead = (fh < 16) && (fv < 6) && (fh % 8 == 0);
            checks++; if (oRamRead2 !== expRead) begin errors++; $display("FAIL wrap_read fh %0d fv %0d got %0b want %0b", fh, fv, oRamRead2, expRead); end
            if (expRead) begin
                checks++; if (oRamAddress2 !== 16'(fv * 2 + fh / 8)) begin errors++; $display("FAIL wrap_addr got %0d want %0d", oRamAddress2, fv * 2 + fh / 8); end
                if (fh == 0 && fv == 0 && lastAddr >= 0) begin
                    checks++; if (lastAddr != 11) begin errors++; $display("FAIL wrap_last_addr got %0d want 11", lastAddr); end
                end
                lastAddr = int'(oRamAddress2);
            end
            expFs = (dispPos(n, FRAME2) == 0);
            checks++; if (oFrameStart2 !== expFs) begin errors++; $display("FAIL wrap_fs n %0d got %0b want %0b", n, oFrameStart2, expFs); end
            if (oFrameStart2 === 1'b1) pulses++;
            tick();
        end
        checks++; if (pulses != 2) begin errors++; $display("FAIL wrap_pulses got %0d want 2", pulses); end
    endtask

    // Pause five cycles while column 3 of row 2 is on display.
    task automatic test_pause();
        int guard;
        guard = 0;
        while (dispPos(n, FRAME) != 2 * 800 + 3 && guard < 2000) begin
            tick();
            guard++;
        end
        checks++; if (guard >= 2000) begin errors++; $display("FAIL pause_seek got timeout want col 3"); end
        Enable = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            checks++; if (oColumn !== 10'd3 || oRow !== 10'd2) begin errors++; $display("FAIL pause_pos got %0d,%0d want 3,2", oColumn, oRow); end
            checks++; if (oPixel !== expPix(3, 2)) begin errors++; $display("FAIL pause_pix got %0d want %0d", oPixel, expPix(3, 2)); end
            checks++; if (oRamRead !== 1'b0) begin errors++; $display("FAIL pause_read got %0b want 0", oRamRead); end
            checks++; if (oRamAddress !== 16'd161) begin errors++; $display("FAIL pause_addr got %0d want 161", oRamAddress); end
            tick();
        end
        Enable = 1'b1;
        for (int k = 4; k <= 7; k++) begin
            tick();
            checks++; if (oColumn !== 10'(k)) begin errors++; $display("FAIL resume_col got %0d want %0d", oColumn, k); end
            checks++; if (oPixel !== expPix(k, 2)) begin errors++; $display("FAIL resume_pix col %0d got %0d want %0d", k, oPixel, expPix(k, 2)); end
        end
    endtask

    task automatic test_async_reset();
        repeat (37) tick();
        @(posedge Clock);
        #2;
        Enable = 1'b0;
        #1;
        Reset = 1'b1;
        #1;
        checks++; if (oColumn !== 10'd798 || oRow !== 10'd520) begin errors++; $display("FAIL areset_pos got %0d,%0d want 798,520", oColumn, oRow); end
        checks++; if (oPixel !== 3'd0) begin errors++; $display("FAIL areset_pix got %0d want 0", oPixel); end
        checks++; if (oRamAddress !== 16'd0 || oRamRead !== 1'b0) begin errors++; $display("FAIL areset_ram got %0d/%0b want 0/0", oRamAddress, oRamRead); end
        checks++; if (oFrameStart !== 1'b0) begin errors++; $display("FAIL areset_fs got %0b want 0", oFrameStart); end
        tick();
        Reset = 1'b0;
        n = 0;
        Enable = 1'b1;
        #1;
        checks++; if (oRamRead !== 1'b1 || oRamAddress !== 16'd0) begin errors++; $display("FAIL rerun_read got %0b/%0d want 1/0", oRamRead, oRamAddress); end
        tick();
        tick();
        checks++; if (oColumn !== 10'd0 || oRow !== 10'd0 || oFrameStart !== 1'b1) begin errors++; $display("FAIL rerun_pos got %0d,%0d fs %0b want 0,0 fs 1", oColumn, oRow, oFrameStart); end
        checks++; if (oPixel !== expPix(0, 0)) begin errors++; $display("FAIL rerun_pix got %0d want %0d", oPixel, expPix(0, 0)); end
    endtask

    initial begin
        test_reset();
        test_first_word();
        test_hblank();
        test_frame_wrap();
        test_pause();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
